hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage load-use hazard and forwarding logic.
- Keeps an in-flight scoreboard of destination registers for stages EX..WB.
- Generates stall, bubble, flush and per-operand forwarding selects for any pipeline depth and load latency.
- Sits beside the ID/EX boundary; drives PC/IF_ID write enables and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages; index 0=EX, 1=MEM, ..., DEPTH-1=WB. Must satisfy DEPTH >= LOAD_LAT+2.
- LOAD_LAT, 1, extra stages before load data can be forwarded. ALU results are forwardable from index 1; load results from index 1+LOAD_LAT.
- FW, $clog2(DEPTH), forwarding-select width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  global pipeline hold (e.g. memory wait).
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1  sources are actually read.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  clear IF/ID.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- fwd_a, fwd_b  out  FW  EX operand source: 0 = register file, k = stage index k.
- stall  out  1  load-use stall active.

Behaviour:
- Scoreboard entry e[i], i = 0..DEPTH-1, fields: v, rd, wr, ld, rs1, rs2, u1, u2.
- Reset (async, reset=0): all e[i].v=0. Outputs: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=0, stall=0. Release is synchronous to clk.
- Hazard match h(i, rs, used): e[i].v && e[i].wr && e[i].ld && e[i].rd != 0 && e[i].rd == rs && used && i < LOAD_LAT.
- Load-use stall, combinational: stall = id_valid && !ex_branch_taken && OR over i of h(i, id_rs1, id_rs1_used) or h(i, id_rs2, id_rs2_used).
- Flush has priority over stall:
  - ex_branch_taken=1 gives if_id_flush=1 and id_ex_bubble=1, with pc_write=1 and if_id_write=1 (the branch target loads).
- Stall:
  - stall=1 gives pc_write=0, if_id_write=0, id_ex_bubble=1.
- Freeze: freeze=1 gives pc_write=0 and if_id_write=0; if_id_flush and id_ex_bubble are forced 0; the scoreboard holds. Freeze overrides flush and stall. A branch seen during freeze is ignored by this block; the EX stage must hold ex_branch_taken until freeze drops.
- Update on each clk edge when freeze=0:
  - e[i] <= e[i-1] for i >= 1.
  - e[0] <= ID fields, with v = id_valid && !id_ex_bubble.
  - The entry leaving the WB index is discarded.
- Forwarding, combinational from e[0] sources:
  - fwd_a = smallest k in 1..DEPTH-1 where e[k].v && e[k].wr && e[k].rd != 0 && e[k].rd == e[0].rs1 && e[0].u1; else 0. The youngest producer wins.
  - fwd_b is the same using rs2/u2.
  - If e[0].v=0, fwd_a=fwd_b=0.
- Assertion (simulation only): a selected k with e[k].ld && k < 1+LOAD_LAT must never occur.
- Register x0 never causes a stall or a forward.
- Register-file write-through in WB is assumed. An ID read of a register being written in the WB cycle needs no stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0], both reset to 0. They increment on each non-frozen cycle with stall=1 or ex_branch_taken=1 respectively, and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw x5 (DEPTH=3, LOAD_LAT=1) followed by add x6,x5,x1 -> exactly 1 cycle with stall=1, pc_write=0, id_ex_bubble=1; next cycle the add is in EX with fwd_a=2.
- add x5 then sub x7,x5,x5 back-to-back -> no stall; fwd_a=fwd_b=1. One instruction later -> fwd=2. Two later -> fwd=0.
- ex_branch_taken=1 at the same cycle as a load-use match -> if_id_flush=1, id_ex_bubble=1, stall=0, pc_write=1.
- Writes to x0 followed by a read of x0 -> stall=0, fwd_a=0 throughout.
- DEPTH=5, LOAD_LAT=3: lw x9 then use -> 3 stall cycles, then fwd=4. freeze=1 mid-stall for 2 cycles -> scoreboard held, stall count still 3 non-frozen cycles.
- reset asserted (reset=0) mid-stall -> outputs return to reset values immediately without a clock edge. With HAZARD_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: parametrised load-use hazard and operand-forwarding unit.
// Tracks destination registers of in-flight instructions from EX (index 0)
// to WB (index DEPTH-1) and drives PC/IF_ID enables, flush, bubble and the
// EX operand forwarding selects.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush
// cycle counters (stall_cycles, flush_cycles).
module hazard_scoreboard #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned FW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_branch_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
`ifdef HAZARD_PERF_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles,
`endif
   output logic              stall
);

   localparam int unsigned CNT_W = 32;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              u1;
      logic              u2;
   } entry_t;

   entry_t          r_sb [DEPTH];
   entry_t          w_id_entry;
   logic            w_hit;
   logic            w_stall;
   logic [FW-1:0]   w_fwd_a;
   logic [FW-1:0]   w_fwd_b;
   logic            w_early_a;
   logic            w_early_b;

   // Load-use match: a load still too young to forward feeds an ID source
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < int'(LOAD_LAT); i++) begin
         if (r_sb[i].v && r_sb[i].wr && r_sb[i].ld && (r_sb[i].rd != '0)) begin
            if (id_rs1_used && (r_sb[i].rd == id_rs1)) w_hit = 1'b1;
            if (id_rs2_used && (r_sb[i].rd == id_rs2)) w_hit = 1'b1;
         end
      end
      w_stall = id_valid && !ex_branch_taken && w_hit;
   end

   // Forward select for the EX operands; scan oldest to youngest so the youngest producer wins
   always_comb begin
      w_fwd_a   = '0;
      w_fwd_b   = '0;
      w_early_a = 1'b0;
      w_early_b = 1'b0;
      if (r_sb[0].v) begin
         for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            if (r_sb[k].v && r_sb[k].wr && (r_sb[k].rd != '0)) begin
               if (r_sb[0].u1 && (r_sb[k].rd == r_sb[0].rs1)) begin
                  w_fwd_a   = FW'(k);
                  w_early_a = r_sb[k].ld && (k < 1 + int'(LOAD_LAT));
               end
               if (r_sb[0].u2 && (r_sb[k].rd == r_sb[0].rs2)) begin
                  w_fwd_b   = FW'(k);
                  w_early_b = r_sb[k].ld && (k < 1 + int'(LOAD_LAT));
               end
            end
         end
      end
   end

   // Pipeline control: reset values first, then freeze > flush > stall
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall        = 1'b0;
      fwd_a        = '0;
      fwd_b        = '0;
      if (reset) begin
         stall = w_stall;
         fwd_a = w_fwd_a;
         fwd_b = w_fwd_b;
         if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
         end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   // Entry captured from ID; a bubbled or empty slot is marked invalid
   always_comb begin
      w_id_entry     = '0;
      w_id_entry.v   = id_valid && !id_ex_bubble;
      w_id_entry.rd  = id_rd;
      w_id_entry.wr  = id_reg_write;
      w_id_entry.ld  = id_mem_read;
      w_id_entry.rs1 = id_rs1;
      w_id_entry.rs2 = id_rs2;
      w_id_entry.u1  = id_rs1_used;
      w_id_entry.u2  = id_rs2_used;
   end

   // Scoreboard shift EX->WB; holds while frozen, oldest entry drops off at WB
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_sb[i] <= '0;
         end
      end else if (!freeze) begin
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_sb[i] <= r_sb[i-1];
         end
         r_sb[0] <= w_id_entry;
      end
   end

   // A load must never be forwarded before its data is available
   always_ff @(posedge clk) begin
      if (reset) begin
         a_no_early_fwd_a : assert (!w_early_a);
         a_no_early_fwd_b : assert (!w_early_b);
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating counts of non-frozen stall and flush cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!freeze) begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (ex_branch_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cnt;
   assign flush_cycles = r_flush_cnt;
`endif

endmodule
